// File: rtl/abr_onehot_rr_arbiter_pkg.sv
// Shared types for the one-hot round-robin arbiter: FSM state encoding.
package abr_onehot_rr_arbiter_pkg;

    // Sparse encodings, pairwise Hamming distance >= 3, so one flipped bit never aliases a legal state.
    typedef enum logic [5:0] {
        IDLE  = 6'b000111,
        GRANT = 6'b111000,
        ERROR = 6'b101101
    } abr_state_e;

endpackage

// File: rtl/abr_prim_onehot_check.sv
// Combinational consistency check of a one-hot vector against its binary index and an enable.
module abr_prim_onehot_check #(
    parameter int unsigned AddrWidth   = 2,
    parameter int unsigned OneHotWidth = 4,
    parameter bit          AddrCheck   = 1'b1,
    parameter bit          EnableCheck = 1'b1,
    parameter bit          StrictCheck = 1'b1
) (
    input  logic [OneHotWidth-1:0] oh_i,
    input  logic [AddrWidth-1:0]   addr_i,
    input  logic                   en_i,
    output logic                   err_o
);

    logic [OneHotWidth-1:0] oh_exp;
    logic                   any_set;
    logic                   multi_err;
    logic                   addr_err;
    logic                   en_err;
    logic                   strict_err;

    assign any_set    = |oh_i;
    assign oh_exp     = {{(OneHotWidth-1){1'b0}}, 1'b1} << addr_i;
    // x & (x-1) clears the lowest set bit; anything left means more than one bit.
    assign multi_err  = |(oh_i & (oh_i - {{(OneHotWidth-1){1'b0}}, 1'b1}));
    assign addr_err   = AddrCheck   && any_set && (oh_i != oh_exp);
    assign en_err     = EnableCheck && any_set && !en_i;
    assign strict_err = StrictCheck && en_i && !any_set;

    assign err_o = multi_err | addr_err | en_err | strict_err;

endmodule

// File: rtl/abr_onehot_rr_arbiter.sv
// Round-robin arbiter with locked, registered one-hot grant and a sticky integrity error.
module abr_onehot_rr_arbiter
    import abr_onehot_rr_arbiter_pkg::*;
#(
    parameter int unsigned NumReq         = 4,
    parameter int unsigned IdxWidth       = $clog2(NumReq),
    parameter bit          EnableErrCheck = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_b,
    input  logic [NumReq-1:0]   req_i,
    input  logic                ready_i,
    output logic                valid_o,
    output logic [NumReq-1:0]   gnt_o,
    output logic [IdxWidth-1:0] idx_o,
    output logic                err_o
);

    abr_state_e          state_q, state_d;
    logic [IdxWidth-1:0] ptr_q, ptr_d;
    logic [IdxWidth-1:0] idx_q, idx_d;
    logic [NumReq-1:0]   gnt_q, gnt_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;

    logic                handshake;
    logic [IdxWidth-1:0] ptr_inc;
    logic [IdxWidth-1:0] base;
    logic [2*NumReq-1:0] req_rot;
    logic [IdxWidth-1:0] pick_idx;
    logic [NumReq-1:0]   pick_oh;
    logic                chk_err;

    assign handshake = (state_q == GRANT) && ready_i;
    assign ptr_inc   = (idx_q == IdxWidth'(NumReq - 1)) ? '0 : idx_q + IdxWidth'(1);
    // Searching from idx_q+1 puts the served index last, so it only wins when it is the sole requester.
    assign base      = handshake ? ptr_inc : ptr_q;
    assign req_rot   = {req_i, req_i} >> base;

    always_comb begin
        pick_idx = '0;
        for (int k = NumReq - 1; k >= 0; k--) begin
            if (req_rot[k]) pick_idx = IdxWidth'((int'(base) + k) % int'(NumReq));
        end
    end

    assign pick_oh = {{(NumReq-1){1'b0}}, 1'b1} << pick_idx;

    generate
        if (EnableErrCheck) begin : g_chk
            abr_prim_onehot_check #(
                .AddrWidth   (IdxWidth),
                .OneHotWidth (NumReq),
                .AddrCheck   (1'b1),
                .EnableCheck (1'b1),
                .StrictCheck (1'b1)
            ) u_onehot_check (
                .oh_i   (gnt_q),
                .addr_i (idx_q),
                .en_i   (valid_q),
                .err_o  (chk_err)
            );
        end else begin : g_no_chk
            assign chk_err = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        gnt_d   = gnt_q;
        valid_d = valid_q;
        unique case (state_q)
            IDLE: begin
                if (|req_i) begin
                    state_d = GRANT;
                    gnt_d   = pick_oh;
                    idx_d   = pick_idx;
                    valid_d = 1'b1;
                end
            end
            GRANT: begin
                if (ready_i) begin
                    ptr_d = ptr_inc;
                    if (|req_i) begin
                        gnt_d = pick_oh;
                        idx_d = pick_idx;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        idx_d   = '0;
                        valid_d = 1'b0;
                    end
                end
            end
            ERROR: begin
                gnt_d   = '0;
                idx_d   = '0;
                valid_d = 1'b0;
            end
            default: begin
                state_d = ERROR;
                gnt_d   = '0;
                idx_d   = '0;
                valid_d = 1'b0;
            end
        endcase
        if (chk_err) begin
            state_d = ERROR;
            gnt_d   = '0;
            idx_d   = '0;
            valid_d = 1'b0;
        end
    end

    assign err_d = (state_d == ERROR);

    always_ff @(posedge clk_i or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign valid_o = valid_q;
    assign gnt_o   = gnt_q;
    assign idx_o   = idx_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_abr_onehot_rr_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a round-robin reference model.
module tb_abr_onehot_rr_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;

    logic          clk_i = 1'b0;
    logic          rst_b;
    logic [N-1:0]  req_i;
    logic          ready_i;
    logic          valid_o;
    logic [N-1:0]  gnt_o;
    logic [IW-1:0] idx_o;
    logic          err_o;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: whether a grant is outstanding, which index, and the search start.
    bit m_valid;
    int m_idx;
    int m_ptr;

    abr_onehot_rr_arbiter #(.NumReq(N), .IdxWidth(IW), .EnableErrCheck(1'b1)) dut (
        .clk_i   (clk_i),
        .rst_b   (rst_b),
        .req_i   (req_i),
        .ready_i (ready_i),
        .valid_o (valid_o),
        .gnt_o   (gnt_o),
        .idx_o   (idx_o),
        .err_o   (err_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [N-1:0] exp_gnt();
        logic [N-1:0] one;
        one = 1;
        return m_valid ? (one << m_idx) : '0;
    endfunction

    task automatic model_reset();
        m_valid = 0;
        m_idx   = 0;
        m_ptr   = 0;
    endtask

    task automatic model_step(input logic [N-1:0] req, input logic rdy);
        if (m_valid && !rdy) return;
        if (m_valid) m_ptr = (m_idx + 1) % N;
        m_valid = 0;
        m_idx   = 0;
        for (int i = 0; i < N; i++) begin
            int j;
            j = (m_ptr + i) % N;
            if (req[j] && !m_valid) begin
                m_valid = 1;
                m_idx   = j;
            end
        end
    endtask

    // One clock: the model sees the same inputs the DUT sampled; outputs read 1 time unit later.
    task automatic step();
        @(posedge clk_i);
        model_step(req_i, ready_i);
        #1;
    endtask

    task automatic test_reset();
        rst_b   = 1'b0;
        req_i   = '0;
        ready_i = 1'b0;
        model_reset();
        @(posedge clk_i);
        #1;
        n_cmp++;
        if ({valid_o, gnt_o, idx_o, err_o} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got v=%b g=%b i=%0d e=%b, want all 0", valid_o, gnt_o, idx_o, err_o);
        end
        rst_b = 1'b1;
    endtask

    task automatic test_round_robin();
        int exp_seq[5] = '{0, 1, 2, 3, 0};
        test_reset();
        req_i   = 4'b1111;
        ready_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            n_cmp++;
            if (!valid_o || idx_o !== IW'(exp_seq[c]) || gnt_o !== exp_gnt() || err_o !== 1'b0) begin
                n_err++;
                $display("FAIL rr_seq[%0d]: got v=%b i=%0d g=%b e=%b, want v=1 i=%0d", c, valid_o, idx_o, gnt_o, err_o, exp_seq[c]);
            end
        end
    endtask

    task automatic test_wrap();
        test_reset();
        req_i   = 4'b0100;
        ready_i = 1'b1;
        step();
        req_i = 4'b0101;
        step();
        n_cmp++;
        if (!valid_o || idx_o !== 2'd0) begin
            n_err++;
            $display("FAIL wrap_from_3: got v=%b i=%0d, want v=1 i=0", valid_o, idx_o);
        end
        step();
        n_cmp++;
        if (!valid_o || idx_o !== 2'd2) begin
            n_err++;
            $display("FAIL wrap_next: got v=%b i=%0d, want v=1 i=2", valid_o, idx_o);
        end
    endtask

    task automatic test_lock();
        test_reset();
        req_i   = 4'b0010;
        ready_i = 1'b0;
        step();
        for (int c = 0; c < 5; c++) begin
            if (c == 2) req_i = 4'b0000;
            step();
            n_cmp++;
            if (!valid_o || gnt_o !== 4'b0010 || idx_o !== 2'd1) begin
                n_err++;
                $display("FAIL lock_hold[%0d]: got v=%b g=%b, want v=1 g=0010", c, valid_o, gnt_o);
            end
        end
        ready_i = 1'b1;
        step();
        n_cmp++;
        if (valid_o !== 1'b0 || gnt_o !== 4'b0000) begin
            n_err++;
            $display("FAIL lock_release: got v=%b g=%b, want v=0 g=0000", valid_o, gnt_o);
        end
    endtask

    task automatic test_sole();
        test_reset();
        req_i   = 4'b0100;
        ready_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            n_cmp++;
            if (!valid_o || idx_o !== 2'd2 || gnt_o !== 4'b0100) begin
                n_err++;
                $display("FAIL sole_regrant[%0d]: got v=%b i=%0d, want v=1 i=2", c, valid_o, idx_o);
            end
        end
    endtask

    task automatic test_ready_idle();
        test_reset();
        req_i   = '0;
        ready_i = 1'b1;
        for (int c = 0; c < 3; c++) step();
        n_cmp++;
        if (valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL idle_no_valid: got v=%b, want 0", valid_o);
        end
        req_i = 4'b1010;
        step();
        n_cmp++;
        if (!valid_o || idx_o !== 2'd1) begin
            n_err++;
            $display("FAIL idle_ptr_kept: got v=%b i=%0d, want v=1 i=1", valid_o, idx_o);
        end
    endtask

    task automatic test_random();
        test_reset();
        for (int c = 0; c < 300; c++) begin
            req_i   = N'($urandom_range(0, (1 << N) - 1));
            ready_i = ($urandom_range(0, 2) != 0);
            step();
            n_cmp++;
            if (valid_o !== m_valid || gnt_o !== exp_gnt() || idx_o !== IW'(m_idx) || err_o !== 1'b0) begin
                n_err++;
                $display("FAIL random[%0d]: got v=%b g=%b i=%0d e=%b, want v=%b g=%b i=%0d e=0",
                         c, valid_o, gnt_o, idx_o, err_o, m_valid, exp_gnt(), m_idx);
            end
        end
    endtask

    task automatic test_error();
        test_reset();
        req_i   = 4'b0010;
        ready_i = 1'b0;
        step();
        @(negedge clk_i);
        force dut.gnt_q = 4'b0110;
        @(posedge clk_i);
        #1;
        release dut.gnt_q;
        n_cmp++;
        if (err_o !== 1'b1) begin
            n_err++;
            $display("FAIL err_raise: got e=%b, want 1", err_o);
        end
        @(posedge clk_i);
        #1;
        n_cmp++;
        if (gnt_o !== 4'b0000 || valid_o !== 1'b0 || err_o !== 1'b1) begin
            n_err++;
            $display("FAIL err_outputs: got g=%b v=%b e=%b, want g=0000 v=0 e=1", gnt_o, valid_o, err_o);
        end
        req_i   = 4'b1111;
        ready_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk_i);
            #1;
            n_cmp++;
            if (err_o !== 1'b1 || valid_o !== 1'b0 || gnt_o !== 4'b0000) begin
                n_err++;
                $display("FAIL err_terminal[%0d]: got e=%b v=%b g=%b, want e=1 v=0 g=0000", c, err_o, valid_o, gnt_o);
            end
        end
        test_reset();
        n_cmp++;
        if (err_o !== 1'b0) begin
            n_err++;
            $display("FAIL err_cleared: got e=%b, want 0", err_o);
        end
    endtask

    task automatic test_async_reset();
        test_reset();
        req_i   = 4'b1111;
        ready_i = 1'b1;
        step();
        step();
        #2;
        rst_b = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (valid_o !== 1'b0 || gnt_o !== 4'b0000 || idx_o !== 2'd0 || err_o !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: got v=%b g=%b i=%0d e=%b, want all 0", valid_o, gnt_o, idx_o, err_o);
        end
        @(negedge clk_i);
        rst_b = 1'b1;
        req_i = 4'b0110;
        step();
        n_cmp++;
        if (!valid_o || idx_o !== 2'd1 || gnt_o !== 4'b0010) begin
            n_err++;
            $display("FAIL post_reset_grant: got v=%b i=%0d g=%b, want v=1 i=1 g=0010", valid_o, idx_o, gnt_o);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_wrap();
        test_lock();
        test_sole();
        test_ready_idle();
        test_random();
        test_error();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
